// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage payload structs and their bubble encodings.
package pipe_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OCC_W = 2;
    localparam int unsigned INC_W = 2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [31:0]      instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rd;
        logic [3:0]       alu_op;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]  alu_res;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]  wb_data;
        logic [REG_W-1:0] rd;
        logic             reg_we;
    } mem_wb_t;

    // Bubbles: no architectural side effect (all write/mem enables low).
    localparam if_id_t  IF_ID_BUBBLE  = '{pc: '0, instr: NOP_INSTR};
    localparam id_ex_t  ID_EX_BUBBLE  = '0;
    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with increment 0..2 and synchronous active-low clear.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    localparam int unsigned SUM_W = W + 1;

    logic [SUM_W-1:0] sum;
    logic [W-1:0]     count_nxt;

    // Carry out of the widened sum means the counter would wrap: clamp instead.
    always_comb begin
        sum       = {1'b0, count} + SUM_W'(inc);
        count_nxt = sum[W] ? '1 : sum[W-1:0];
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, flush, optional skid entry,
// and a saturating count of held beats killed by flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = 64,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] kill_cnt
);

    logic             m_valid;
    logic             m_valid_nxt;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_data_nxt;
    logic             s_valid;
    logic             in_fire;
    logic             out_fire;
    logic [INC_W-1:0] kill_inc;

    // Flush masks the presented beat in the same cycle.
    assign out_valid = m_valid && !flush;
    assign out_data  = out_valid ? m_data : BUBBLE;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign occupancy = OCC_W'(m_valid) + OCC_W'(s_valid);
    assign kill_inc  = flush ? INC_W'(occupancy) : '0;

    if (SKID) begin : g_skid
        logic             s_valid_nxt;
        logic [WIDTH-1:0] s_data;
        logic [WIDTH-1:0] s_data_nxt;

        // Registered ready: accept whenever the skid slot is free.
        assign in_ready = rst_n && !s_valid;

        // Two-entry FIFO next state; skid always drains into main first to keep order.
        always_comb begin
            m_valid_nxt = m_valid;
            m_data_nxt  = m_data;
            s_valid_nxt = s_valid;
            s_data_nxt  = s_data;
            if (flush) begin
                m_valid_nxt = 1'b0;
                m_data_nxt  = BUBBLE;
                s_valid_nxt = 1'b0;
                s_data_nxt  = BUBBLE;
            end else if (!m_valid || out_fire) begin
                if (s_valid) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = s_data;
                end else if (in_fire) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = in_data;
                end else begin
                    m_valid_nxt = 1'b0;
                    m_data_nxt  = BUBBLE;
                end
                if (s_valid && in_fire) begin
                    s_valid_nxt = 1'b1;
                    s_data_nxt  = in_data;
                end else begin
                    s_valid_nxt = 1'b0;
                    s_data_nxt  = BUBBLE;
                end
            end else if (in_fire) begin
                s_valid_nxt = 1'b1;
                s_data_nxt  = in_data;
            end
        end

        // Skid entry register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s_valid <= 1'b0;
                s_data  <= BUBBLE;
            end else begin
                s_valid <= s_valid_nxt;
                s_data  <= s_data_nxt;
            end
        end
    end else begin : g_single
        // Combinational ready: accept when empty or when the held beat leaves now.
        assign in_ready = rst_n && (!m_valid || out_ready);
        assign s_valid  = 1'b0;

        // Single-entry next state; a new beat replaces a departing one.
        always_comb begin
            m_valid_nxt = m_valid;
            m_data_nxt  = m_data;
            if (flush) begin
                m_valid_nxt = 1'b0;
                m_data_nxt  = BUBBLE;
            end else if (in_fire) begin
                m_valid_nxt = 1'b1;
                m_data_nxt  = in_data;
            end else if (out_fire) begin
                m_valid_nxt = 1'b0;
                m_data_nxt  = BUBBLE;
            end
        end
    end

    // Main entry register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE;
        end else begin
            m_valid <= m_valid_nxt;
            m_data  <= m_data_nxt;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_kill_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (kill_inc),
        .count (kill_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid instance checked by a scoreboard, single-entry instance by direct checks.
module tb_pipe_stage_reg;

    localparam int unsigned W   = 32;
    localparam logic [31:0] BUB = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
    logic [1:0]   kill_cnt;

    logic         z_flush;
    logic         z_in_valid;
    logic         z_in_ready;
    logic [W-1:0] z_in_data;
    logic         z_out_valid;
    logic         z_out_ready;
    logic [W-1:0] z_out_data;
    logic [1:0]   z_occ;
    logic [1:0]   z_kill;

    int           total = 0;
    int           bad   = 0;
    int           pops  = 0;
    logic [31:0]  q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .BUBBLE(BUB), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .kill_cnt(kill_cnt)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(1'b0), .BUBBLE(BUB), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .occupancy(z_occ), .kill_cnt(z_kill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sample before the rising edge, update the scoreboard, then advance to the next falling edge.
    task automatic tick();
        logic [31:0] e;
        #2;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_extra_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_data", out_data, e);
                    pops++;
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(in_data);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 1'b0;

        // Reset
        @(negedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, BUB);
        check("rst_kill", 32'(kill_cnt), 32'd0);
        tick();
        rst_n = 1'b1; #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_occ", 32'(occupancy), 32'd0);
        check("post_rst_z_in_ready", 32'(z_in_ready), 32'd1);

        // Streaming 1..8 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i); #1;
            if (i > 1) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", out_data, 32'(i - 1));
            end
            check("stream_occ_le1", 32'(occupancy <= 2'd1), 32'd1);
            tick();
        end
        in_valid = 1'b0; #1;
        check("stream_last", out_data, 32'd8);
        tick(); #1;
        check("stream_drained", 32'(out_valid), 32'd0);

        // Back-pressure: A,B,C
        in_valid = 1'b1; in_data = 32'hA; tick();
        out_ready = 1'b0; in_data = 32'hB; #1;
        check("bp_present_a", out_data, 32'hA);
        tick();
        in_data = 32'hC; #1;
        check("bp_occ2", 32'(occupancy), 32'd2);
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        check("bp_hold_a", out_data, 32'hA);
        tick();
        out_ready = 1'b1; #1;
        check("bp_release_ready0", 32'(in_ready), 32'd0);
        tick(); #1;
        check("bp_ready_rise", 32'(in_ready), 32'd1);
        check("bp_present_b", out_data, 32'hB);
        tick();
        in_valid = 1'b0; #1;
        check("bp_present_c", out_data, 32'hC);
        tick(); #1;
        check("bp_empty", 32'(occupancy), 32'd0);

        // Flush with two held and an incoming beat
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD; tick();
        in_data = 32'hE; tick(); #1;
        check("fl_occ2", 32'(occupancy), 32'd2);
        flush = 1'b1; in_data = 32'hF; out_ready = 1'b1; #1;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_data", out_data, BUB);
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        check("fl_occ0", 32'(occupancy), 32'd0);
        check("fl_kill2", 32'(kill_cnt), 32'd2);
        check("fl_no_beat", 32'(out_valid), 32'd0);
        tick(); tick();

        // Saturation at CNT_W=2
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h10; tick();
        in_data = 32'h11; tick();
        flush = 1'b1; in_valid = 1'b0; tick();
        flush = 1'b0; #1;
        check("sat_kill3", 32'(kill_cnt), 32'd3);
        check("sat_occ0", 32'(occupancy), 32'd0);
        in_valid = 1'b1; in_data = 32'h12; tick();
        flush = 1'b1; out_ready = 1'b1; in_data = 32'h13; #1;
        check("sat_in_ready_hi", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        check("sat_hold3", 32'(kill_cnt), 32'd3);
        check("sat_occ0b", 32'(occupancy), 32'd0);
        tick(); tick();

        // Reset mid-stream with flush
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h20; tick();
        in_data = 32'h21; tick(); #1;
        check("rs_occ2", 32'(occupancy), 32'd2);
        rst_n = 1'b0; flush = 1'b1; in_data = 32'h22; #1;
        check("rs_in_ready0", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; #1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_out_data", out_data, BUB);
        check("rs_occ0", 32'(occupancy), 32'd0);
        check("rs_kill0", 32'(kill_cnt), 32'd0);
        check("rs_in_ready1", 32'(in_ready), 32'd1);

        // Single-entry mode: combinational ready
        z_out_ready = 1'b0; z_in_valid = 1'b1; z_in_data = 32'h11; #1;
        check("z_empty_ready", 32'(z_in_ready), 32'd1);
        tick();
        z_in_data = 32'h22; #1;
        check("z_full_ready0", 32'(z_in_ready), 32'd0);
        check("z_occ1", 32'(z_occ), 32'd1);
        check("z_hold", z_out_data, 32'h11);
        tick();
        z_out_ready = 1'b1; #1;
        check("z_ready_same_cycle", 32'(z_in_ready), 32'd1);
        check("z_present_11", z_out_data, 32'h11);
        tick();
        z_in_valid = 1'b0; #1;
        check("z_next_valid", 32'(z_out_valid), 32'd1);
        check("z_next_data", z_out_data, 32'h22);
        tick(); #1;
        check("z_drained", 32'(z_out_valid), 32'd0);
        check("z_bubble", z_out_data, BUB);
        check("z_occ0", 32'(z_occ), 32'd0);

        // Scoreboard accounting: 8 streamed + A,B,C
        check("sb_pops", 32'(pops), 32'd11);
        check("sb_left", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
